piece_drop_ctrl: RTL and testbench
==================================

Name: piece_drop_ctrl

Overview:
- Sequences the falling tetromino: spawns it, applies gravity and player moves, checks each move for collision against the board occupancy RAM, and hands the piece to the board writer when it lands.
- Drives the four cell coordinates consumed by draw_block.
- Sits between the keyboard decoder, the frame_clk timebase, the board occupancy RAM and the draw_block/colour mapper.

Parameters:
- COLS, 10, board width in cells.
- ROWS, 20, board height in cells.
- DROP_FRAMES, 30, frame_clk rising edges per gravity step (1..255).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  vertical-sync-rate timebase, asynchronous to Clk
- spawn_req  in  1  level; request a new piece while in IDLE
- spawn_x  in  16  four 4-bit column values, cell0 in [3:0]
- spawn_y  in  20  four 5-bit row values, cell0 in [4:0]
- move_left  in  1  single-cycle pulse
- move_right  in  1  single-cycle pulse
- soft_drop  in  1  single-cycle pulse
- occ_rd  out  1  occupancy read strobe
- occ_x  out  4  read column
- occ_y  out  5  read row
- occ_hit  in  1  occupancy of the cell addressed on the previous cycle (fixed 1-cycle latency)
- lock_valid  out  1  landed piece offered to board writer
- lock_ready  in  1  board writer accepts
- x0, x1, x2, x3  out  10  cell columns, zero-extended
- y0, y1, y2, y3  out  10  cell rows, zero-extended
- piece_active  out  1  piece displayed and movable
- game_over  out  1  sticky; spawn collided

Behaviour:
- Reset (async, Reset=1):
  - state=IDLE; all coordinates 0.
  - piece_active, lock_valid, occ_rd and game_over all 0.
  - Gravity counter 0; pending flags cleared; synchroniser flops 0.
- Reset mid-CHECK or mid-LOCK abandons the operation with no board write.
- frame_clk handling:
  - Passes through a 2-flop synchroniser, then a rising-edge detector.
  - Each edge while in ACTIVE/CHECK/EVAL increments the gravity counter.
  - At DROP_FRAMES the counter returns to 0 and sets down_pend. Otherwise it holds 0.
- Pending flags (left_pend, right_pend, down_pend):
  - Set by pulses in ACTIVE, CHECK and EVAL.
  - Cleared on entry to IDLE.
  - soft_drop sets down_pend.
  - Each flag is one deep: repeats before service coalesce.
- States:
  - IDLE:
    - piece_active=0.
    - If spawn_req and !game_over: load the candidate from spawn_x/spawn_y, kind=SPAWN, go to CHECK.
  - ACTIVE:
    - piece_active=1.
    - Service priority is left > right > down.
    - left_pend and right_pend both set: clear both, no move, evaluate down this cycle.
    - Left: candidate x-1 on all cells. Right: candidate x+1. Down: candidate y+1.
    - The selected flag clears and the FSM goes to CHECK.
    - No flag set: stay.
  - CHECK (4 cycles, idx 0..3):
    - Per idx, present the candidate cell on occ_x/occ_y.
    - occ_rd=1 only if the cell is in bounds (x<COLS and y<ROWS).
    - Out-of-bounds sets blocked directly; x=0 moving left wraps to 15, which is ≥COLS and therefore blocked.
    - occ_hit sampled on the cycle after each strobe ORs into blocked.
  - EVAL (1 cycle):
    - Samples the final occ_hit.
    - SPAWN: blocked → GAME_OVER; clear → commit, ACTIVE.
    - LEFT/RIGHT: blocked → discard; clear → commit. Either way → ACTIVE.
    - DOWN: blocked → LOCK; clear → commit, ACTIVE.
    - Commit updates x*/y* at the clock edge ending EVAL.
  - LOCK:
    - lock_valid=1, x*/y* held stable, piece_active=1.
    - On lock_valid&lock_ready: go to IDLE with lock_valid=0 next cycle.
    - Pulses in LOCK are ignored.
  - GAME_OVER:
    - game_over=1 and piece_active=0. Absorbing until Reset.
- Latency:
  - Request serviced in ACTIVE at cycle t: occ_rd at t+1..t+4, EVAL at t+5, new coordinates visible at t+6.
  - Spawn: spawn_req sampled at t, coordinates visible at t+6.
- Arithmetic:
  - Candidate math uses 4-bit x and 5-bit y, modulo 2^n.
  - y+1 at ROWS-1 gives ROWS, which is out of bounds → blocked.
- Outputs are registered, except occ_rd/occ_x/occ_y, which decode from state and idx.

Test Plan:
- Spawn on an empty board: spawn_x={4,5,4,5}, spawn_y={1,1,0,0} (cell3..cell0). Required: occ_rd high 4 cycles; y0..y3 = 0,0,1,1 at t+6; piece_active=1.
- Gravity with DROP_FRAMES=2: 4 frame_clk edges. Required: rows step +1 twice; no move after the first edge alone.
- Left wall: piece with a cell at x=0, pulse move_left. Required: only 3 occ_rd strobes, coordinates unchanged, back in ACTIVE at t+6.
- Simultaneous move_left and move_right in one cycle with down_pend=0. Required: no CHECK entered, coordinates unchanged.
- Landing: piece on row 19, gravity step. Required: lock_valid=1. Hold lock_ready=0 for 5 cycles → lock_valid and coordinates stable. Then lock_ready=1 → IDLE, piece_active=0.
- Spawn onto an occupied cell (occ_hit=1 for cell2). Required: game_over=1 stays high, spawn_req ignored. Assert Reset mid-CHECK of a later run → all outputs return to reset values immediately.

Source files
------------

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl
// Sequences the falling tetromino. It spawns a piece, applies gravity and
// player moves, and checks every candidate position against the board
// occupancy RAM one cell per cycle. A landed piece is offered to the board
// writer.
//
// Ports
//   Clk, Reset             system clock, asynchronous active-high reset
//   frame_clk              vsync-rate timebase (asynchronous to Clk)
//   spawn_req              level request for a new piece while idle
//   spawn_x / spawn_y      packed spawn cells (4-bit x, 5-bit y each, cell0 in LSBs)
//   move_left/right        single-cycle move pulses
//   soft_drop              single-cycle drop pulse
//   occ_rd/occ_x/occ_y     occupancy RAM read port (combinational decode)
//   occ_hit                occupancy of the cell read on the previous cycle
//   lock_valid/lock_ready  landed-piece handshake with the board writer
//   x0..x3, y0..y3         committed cell coordinates, zero-extended
//   piece_active           piece displayed and movable
//   game_over              sticky, set when a spawn collides
module piece_drop_ctrl #(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int DROP_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        spawn_req,
  input  logic [15:0] spawn_x,
  input  logic [19:0] spawn_y,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        soft_drop,
  output logic        occ_rd,
  output logic [3:0]  occ_x,
  output logic [4:0]  occ_y,
  input  logic        occ_hit,
  output logic        lock_valid,
  input  logic        lock_ready,
  output logic [9:0]  x0,
  output logic [9:0]  x1,
  output logic [9:0]  x2,
  output logic [9:0]  x3,
  output logic [9:0]  y0,
  output logic [9:0]  y1,
  output logic [9:0]  y2,
  output logic [9:0]  y3,
  output logic        piece_active,
  output logic        game_over
);

  localparam logic [4:0] COLS_L    = 5'(COLS);
  localparam logic [5:0] ROWS_L    = 6'(ROWS);
  localparam logic [7:0] GRAV_LAST = 8'(DROP_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_CHECK, S_EVAL, S_LOCK, S_GAME_OVER
  } state_t;

  typedef enum logic [1:0] {K_SPAWN, K_LEFT, K_RIGHT, K_DOWN} kind_t;

  state_t      state_q;
  kind_t       kind_q;
  logic [1:0]  idx_q;
  logic        blocked_q;
  logic        rd_prev_q;
  logic [3:0]  cand_x_q [4];
  logic [4:0]  cand_y_q [4];
  logic [3:0]  pos_x_q  [4];
  logic [4:0]  pos_y_q  [4];
  logic        left_pend_q, right_pend_q, down_pend_q;
  logic [1:0]  fsync_q;
  logic        frame_prev_q;
  logic [7:0]  grav_q;
  logic        piece_active_q, lock_valid_q, game_over_q;

  logic        frame_rise, in_play, grav_tick, grav_wrap;
  logic        cell_in_bounds, blocked_d, commit_d;
  logic        do_left, do_right, do_down;

  // Read port decodes straight from the candidate cell selected by idx, so
  // the strobe lines up with the CHECK cycle itself. occ_hit comes back one
  // cycle later; rd_prev_q remembers whether that cycle actually strobed.
  always_comb begin
    frame_rise     = fsync_q[1] & ~frame_prev_q;
    in_play        = (state_q == S_ACTIVE) || (state_q == S_CHECK) || (state_q == S_EVAL);
    grav_tick      = in_play & frame_rise;
    grav_wrap      = grav_tick & (grav_q == GRAV_LAST);
    occ_x          = cand_x_q[idx_q];
    occ_y          = cand_y_q[idx_q];
    cell_in_bounds = ({1'b0, occ_x} < COLS_L) && ({1'b0, occ_y} < ROWS_L);
    occ_rd         = (state_q == S_CHECK) && cell_in_bounds;
    blocked_d      = blocked_q | (rd_prev_q & occ_hit) |
                     ((state_q == S_CHECK) & ~cell_in_bounds);
    commit_d       = (state_q == S_EVAL) && !blocked_d;
    // Opposing left/right requests cancel; down is then serviced instead.
    do_left        = left_pend_q & ~right_pend_q;
    do_right       = right_pend_q & ~left_pend_q;
    do_down        = down_pend_q & ~do_left & ~do_right;
  end

  assign x0 = {6'd0, pos_x_q[0]};
  assign x1 = {6'd0, pos_x_q[1]};
  assign x2 = {6'd0, pos_x_q[2]};
  assign x3 = {6'd0, pos_x_q[3]};
  assign y0 = {5'd0, pos_y_q[0]};
  assign y1 = {5'd0, pos_y_q[1]};
  assign y2 = {5'd0, pos_y_q[2]};
  assign y3 = {5'd0, pos_y_q[3]};
  assign piece_active = piece_active_q;
  assign lock_valid   = lock_valid_q;
  assign game_over    = game_over_q;

  // Main sequencer. Pending-flag sets come last in the block so a pulse
  // arriving in the same cycle its flag is serviced is not lost.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      kind_q         <= K_SPAWN;
      idx_q          <= '0;
      blocked_q      <= 1'b0;
      rd_prev_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cand_x_q[i] <= '0;
        cand_y_q[i] <= '0;
        pos_x_q[i]  <= '0;
        pos_y_q[i]  <= '0;
      end
      left_pend_q    <= 1'b0;
      right_pend_q   <= 1'b0;
      down_pend_q    <= 1'b0;
      fsync_q        <= '0;
      frame_prev_q   <= 1'b0;
      grav_q         <= '0;
      piece_active_q <= 1'b0;
      lock_valid_q   <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      fsync_q      <= {fsync_q[0], frame_clk};
      frame_prev_q <= fsync_q[1];
      rd_prev_q    <= occ_rd;

      if (!in_play)
        grav_q <= '0;
      else if (grav_tick)
        grav_q <= grav_wrap ? 8'd0 : grav_q + 8'd1;

      if (commit_d) begin
        for (int i = 0; i < 4; i++) begin
          pos_x_q[i] <= cand_x_q[i];
          pos_y_q[i] <= cand_y_q[i];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (spawn_req && !game_over_q) begin
            for (int i = 0; i < 4; i++) begin
              cand_x_q[i] <= spawn_x[4*i +: 4];
              cand_y_q[i] <= spawn_y[5*i +: 5];
            end
            kind_q    <= K_SPAWN;
            idx_q     <= '0;
            blocked_q <= 1'b0;
            state_q   <= S_CHECK;
          end
        end
        S_ACTIVE: begin
          if (left_pend_q && right_pend_q) begin
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
          end
          // Candidate math wraps in 4/5 bits; x=0 going left becomes 15,
          // which the bounds check then rejects.
          for (int i = 0; i < 4; i++) begin
            cand_x_q[i] <= do_left  ? pos_x_q[i] - 4'd1 :
                           do_right ? pos_x_q[i] + 4'd1 : pos_x_q[i];
            cand_y_q[i] <= (do_down && !do_left && !do_right) ? pos_y_q[i] + 5'd1
                                                              : pos_y_q[i];
          end
          if (do_left) begin
            kind_q      <= K_LEFT;
            left_pend_q <= 1'b0;
          end else if (do_right) begin
            kind_q       <= K_RIGHT;
            right_pend_q <= 1'b0;
          end else if (do_down) begin
            kind_q      <= K_DOWN;
            down_pend_q <= 1'b0;
          end
          if (do_left || do_right || do_down) begin
            idx_q     <= '0;
            blocked_q <= 1'b0;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          blocked_q <= blocked_d;
          idx_q     <= idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_q <= S_EVAL;
        end
        S_EVAL: begin
          blocked_q <= blocked_d;
          if (kind_q == K_SPAWN && blocked_d) begin
            state_q        <= S_GAME_OVER;
            game_over_q    <= 1'b1;
            piece_active_q <= 1'b0;
          end else if (kind_q == K_DOWN && blocked_d) begin
            state_q        <= S_LOCK;
            lock_valid_q   <= 1'b1;
            piece_active_q <= 1'b1;
          end else begin
            state_q        <= S_ACTIVE;
            piece_active_q <= 1'b1;
          end
        end
        S_LOCK: begin
          if (lock_ready) begin
            state_q        <= S_IDLE;
            lock_valid_q   <= 1'b0;
            piece_active_q <= 1'b0;
            left_pend_q    <= 1'b0;
            right_pend_q   <= 1'b0;
            down_pend_q    <= 1'b0;
          end
        end
        S_GAME_OVER: begin
          state_q <= S_GAME_OVER;
        end
        default: state_q <= S_IDLE;
      endcase

      if (in_play) begin
        if (move_left)
          left_pend_q <= 1'b1;
        if (move_right)
          right_pend_q <= 1'b1;
        if (soft_drop || grav_wrap)
          down_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb_piece_drop_ctrl
// Self-checking bench for piece_drop_ctrl. A behavioural occupancy RAM and
// board writer surround the DUT. For every action a small reference model
// predicts the coordinates, flags and number of read strobes. The prediction
// is queued when the stimulus is driven and popped once the DUT result is
// due.
module tb_piece_drop_ctrl;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int DROP = 2;

  localparam int ACT_SPAWN = 0;
  localparam int ACT_LEFT  = 1;
  localparam int ACT_RIGHT = 2;
  localparam int ACT_DOWN  = 3;
  localparam int ACT_BOTH  = 4;
  localparam int ACT_FRAME = 5;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, spawn_req, move_left, move_right, soft_drop;
  logic        occ_hit, lock_ready;
  logic [15:0] spawn_x;
  logic [19:0] spawn_y;
  logic        occ_rd, lock_valid, piece_active, game_over;
  logic [3:0]  occ_x;
  logic [4:0]  occ_y;
  logic [9:0]  x0, x1, x2, x3, y0, y1, y2, y3;

  int testsRun    = 0;
  int testsFailed = 0;
  int strobeCount = 0;

  bit board [ROWS][COLS];
  int mx [4];
  int my [4];
  int spX [4];
  int spY [4];
  int gravCount;
  bit modelActive, modelLock, modelOver;

  typedef struct {
    string       tag;
    logic [79:0] coords;
    logic [2:0]  flags;
    int          strobes;
  } expT;

  expT sbQueue [$];

  always #5 Clk = ~Clk;

  piece_drop_ctrl #(.COLS(COLS), .ROWS(ROWS), .DROP_FRAMES(DROP)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_req(spawn_req),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .move_left(move_left),
    .move_right(move_right), .soft_drop(soft_drop), .occ_rd(occ_rd),
    .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit), .lock_valid(lock_valid),
    .lock_ready(lock_ready), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .piece_active(piece_active),
    .game_over(game_over)
  );

  // Occupancy RAM with one cycle of read latency, plus a strobe counter.
  always @(posedge Clk) begin
    if (occ_rd)
      strobeCount = strobeCount + 1;
    occ_hit <= (occ_rd && occ_x < 4'd10 && occ_y < 5'd20) ? board[occ_y][occ_x] : 1'b0;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [79:0] dutCoords();
    return {x0, x1, x2, x3, y0, y1, y2, y3};
  endfunction

  function automatic logic [79:0] modelCoords();
    return {10'(mx[0]), 10'(mx[1]), 10'(mx[2]), 10'(mx[3]),
            10'(my[0]), 10'(my[1]), 10'(my[2]), 10'(my[3])};
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scoreResult();
    expT e;
    if (sbQueue.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbQueue.pop_front();
      checkOutput({e.tag, " coords"}, dutCoords(), e.coords);
      checkOutput({e.tag, " flags"}, 80'({piece_active, lock_valid, game_over}), 80'(e.flags));
      checkOutput({e.tag, " strobes"}, 80'(strobeCount), 80'(e.strobes));
    end
  endtask

  // Predicts the outcome of one action, queues it, drives the stimulus and
  // waits until the DUT result is due before scoring it.
  task automatic applyStimulus(input string tag, input int action);
    expT e;
    bit  blk, evalNeeded, isDown;
    int  ns;
    int  cx [4];
    int  cy [4];
    blk = 0; ns = 0; evalNeeded = 0; isDown = 0;
    for (int i = 0; i < 4; i++) begin
      cx[i] = mx[i];
      cy[i] = my[i];
    end
    case (action)
      ACT_SPAWN: if (!modelOver) begin
        evalNeeded = 1;
        for (int i = 0; i < 4; i++) begin cx[i] = spX[i]; cy[i] = spY[i]; end
      end
      ACT_LEFT:  begin evalNeeded = 1; for (int i = 0; i < 4; i++) cx[i] = (mx[i] - 1) & 15; end
      ACT_RIGHT: begin evalNeeded = 1; for (int i = 0; i < 4; i++) cx[i] = (mx[i] + 1) & 15; end
      ACT_DOWN:  begin evalNeeded = 1; isDown = 1; for (int i = 0; i < 4; i++) cy[i] = (my[i] + 1) & 31; end
      ACT_FRAME: begin
        gravCount++;
        if (gravCount == DROP) begin
          gravCount = 0;
          evalNeeded = 1; isDown = 1;
          for (int i = 0; i < 4; i++) cy[i] = (my[i] + 1) & 31;
        end
      end
      default: ;
    endcase
    if (evalNeeded) begin
      for (int i = 0; i < 4; i++) begin
        if (cx[i] < COLS && cy[i] < ROWS) begin
          ns++;
          if (board[cy[i]][cx[i]]) blk = 1;
        end else begin
          blk = 1;
        end
      end
      if (!blk) begin
        for (int i = 0; i < 4; i++) begin mx[i] = cx[i]; my[i] = cy[i]; end
        modelActive = 1;
      end else if (action == ACT_SPAWN) begin
        modelOver = 1; modelActive = 0;
      end else if (isDown) begin
        modelLock = 1;
      end
    end
    e.tag = tag; e.coords = modelCoords();
    e.flags = {modelActive, modelLock, modelOver}; e.strobes = ns;
    sbQueue.push_back(e);

    strobeCount = 0;
    case (action)
      ACT_SPAWN: begin
        spawn_req = 1; tick(1); spawn_req = 0; tick(4);
        checkOutput({tag, " preCommit active"}, 80'(piece_active), 80'(0));
        tick(1);
      end
      ACT_LEFT:  begin move_left = 1;  tick(1); move_left = 0;  tick(6); end
      ACT_RIGHT: begin move_right = 1; tick(1); move_right = 0; tick(6); end
      ACT_DOWN:  begin soft_drop = 1;  tick(1); soft_drop = 0;  tick(6); end
      ACT_BOTH:  begin
        move_left = 1; move_right = 1; tick(1);
        move_left = 0; move_right = 0; tick(6);
      end
      default: begin frame_clk = 1; tick(4); frame_clk = 0; tick(12); end
    endcase
    scoreResult();
  endtask

  task automatic lockHandshake(input string tag);
    repeat (5) begin
      tick(1);
      checkOutput({tag, " hold valid"}, 80'(lock_valid), 80'(1));
      checkOutput({tag, " hold coords"}, dutCoords(), modelCoords());
    end
    lock_ready = 1; tick(1); lock_ready = 0;
    for (int i = 0; i < 4; i++) board[my[i]][mx[i]] = 1;
    modelLock = 0; modelActive = 0; gravCount = 0;
    checkOutput({tag, " done valid"}, 80'(lock_valid), 80'(0));
    checkOutput({tag, " done active"}, 80'(piece_active), 80'(0));
  endtask

  task automatic clearBoard();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 0;
  endtask

  initial begin
    int guard;
    Reset = 1; frame_clk = 0; spawn_req = 0; move_left = 0; move_right = 0;
    soft_drop = 0; lock_ready = 0; spawn_x = '0; spawn_y = '0;
    clearBoard();
    for (int i = 0; i < 4; i++) begin mx[i] = 0; my[i] = 0; end
    gravCount = 0; modelActive = 0; modelLock = 0; modelOver = 0;
    tick(3);
    checkOutput("reset coords", dutCoords(), 80'(0));
    checkOutput("reset flags", 80'({piece_active, lock_valid, game_over, occ_rd}), 80'(0));
    Reset = 0; tick(2);

    // O piece, then gravity, opposing moves, a right move and a landing.
    spawn_x = {4'd4, 4'd5, 4'd4, 4'd5}; spawn_y = {5'd1, 5'd1, 5'd0, 5'd0};
    spX = '{5, 4, 5, 4}; spY = '{0, 0, 1, 1};
    applyStimulus("spawnO", ACT_SPAWN);
    for (int k = 0; k < 4; k++) applyStimulus("gravity", ACT_FRAME);
    applyStimulus("leftRightTogether", ACT_BOTH);
    applyStimulus("moveRight", ACT_RIGHT);
    guard = 0;
    while (my[3] < ROWS - 1 && guard < 25) begin applyStimulus("dropO", ACT_DOWN); guard++; end
    guard = 0;
    while (!modelLock && guard < 10) begin applyStimulus("landO", ACT_FRAME); guard++; end
    checkOutput("landO reached", 80'(lock_valid), 80'(1));
    lockHandshake("lockO");

    // S piece pushed against the left wall, then dropped to the floor.
    spawn_x = {4'd5, 4'd4, 4'd4, 4'd3}; spawn_y = {5'd0, 5'd0, 5'd1, 5'd1};
    spX = '{3, 4, 4, 5}; spY = '{1, 1, 0, 0};
    applyStimulus("spawnS", ACT_SPAWN);
    for (int k = 0; k < 3; k++) applyStimulus("moveLeft", ACT_LEFT);
    applyStimulus("leftWall", ACT_LEFT);
    guard = 0;
    while (!modelLock && guard < 25) begin applyStimulus("dropS", ACT_DOWN); guard++; end
    checkOutput("dropS reached", 80'(lock_valid), 80'(1));
    lockHandshake("lockS");

    // Spawn onto an occupied cell, then a further ignored request.
    spawn_x = {4'd4, 4'd5, 4'd4, 4'd5}; spawn_y = {5'd1, 5'd1, 5'd0, 5'd0};
    spX = '{5, 4, 5, 4}; spY = '{0, 0, 1, 1};
    board[1][5] = 1;
    applyStimulus("spawnBlocked", ACT_SPAWN);
    applyStimulus("spawnAfterOver", ACT_SPAWN);

    // Reset clears game over; a second reset lands in the middle of CHECK.
    Reset = 1; tick(1);
    checkOutput("reset clears over", 80'(game_over), 80'(0));
    Reset = 0; clearBoard(); tick(1);
    spawn_req = 1; tick(1); spawn_req = 0; tick(1);
    checkOutput("midCheck strobe", 80'(occ_rd), 80'(1));
    Reset = 1; #1;
    checkOutput("midCheck reset coords", dutCoords(), 80'(0));
    checkOutput("midCheck reset flags", 80'({piece_active, lock_valid, game_over, occ_rd}), 80'(0));
    tick(2); Reset = 0; tick(8);
    checkOutput("afterReset idle", 80'({piece_active, lock_valid, game_over, occ_rd}), 80'(0));
    checkOutput("afterReset coords", dutCoords(), 80'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
